// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit:
// opcodes, funct codes, ALU codes, FSM states and decode classes.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LH    = 6'b100001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LBU   = 6'b100100;
    localparam logic [5:0] OP_LHU   = 6'b100101;
    localparam logic [5:0] OP_LWU   = 6'b100111;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_SH    = 6'b101001;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] F_SLL  = 6'b000000;
    localparam logic [5:0] F_SRL  = 6'b000010;
    localparam logic [5:0] F_SRA  = 6'b000011;
    localparam logic [5:0] F_SLLV = 6'b000100;
    localparam logic [5:0] F_SRLV = 6'b000110;
    localparam logic [5:0] F_SRAV = 6'b000111;
    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_ADDU = 6'b100001;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_SUBU = 6'b100011;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_XOR  = 6'b100110;
    localparam logic [5:0] F_NOR  = 6'b100111;
    localparam logic [5:0] F_SLT  = 6'b101010;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_NOR = 4'd5;
    localparam logic [3:0] ALU_SLL = 4'd6;
    localparam logic [3:0] ALU_SRL = 4'd7;
    localparam logic [3:0] ALU_SRA = 4'd8;
    localparam logic [3:0] ALU_SLT = 4'd9;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_DECODE   = 3'd1;
    localparam logic [2:0] S_EXEC     = 3'd2;
    localparam logic [2:0] S_MEM_ADDR = 3'd3;
    localparam logic [2:0] S_MEM_WAIT = 3'd4;
    localparam logic [2:0] S_WB       = 3'd5;
    localparam logic [2:0] S_BRANCH   = 3'd6;
    localparam logic [2:0] S_TRAP     = 3'd7;

    typedef enum logic [2:0] {
        CLS_ILL,
        CLS_R,
        CLS_I,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH
    } op_class_e;

    typedef enum logic [1:0] {
        LANE_NONE,
        LANE_B,
        LANE_H,
        LANE_W
    } lane_e;

endpackage

// File: rtl/mips_op_decode.sv
// Combinational op/funct classifier: instruction class, ALU op, operand
// select, fixed shift and byte-lane mask. BEQ/BNE decode under CTRL_BRANCH_EN.
module mips_op_decode
    import mips_ctrl_pkg::*;
#(
    parameter int ALU_CTRL_W = 4,
    parameter int BYTE_EN_W  = 4,
    parameter int SHAMT_W    = 5
) (
    input  logic [5:0]            op,
    input  logic [5:0]            funct,
    output op_class_e             cls,
    output logic [ALU_CTRL_W-1:0] alu_ctrl,
    output logic                  alu_src,
    output logic [SHAMT_W-1:0]    shift_amt,
    output logic [BYTE_EN_W-1:0]  byte_mask
);

    logic [3:0] alu;
    lane_e      lane;

    always_comb begin
        cls       = CLS_ILL;
        alu       = ALU_ADD;
        alu_src   = 1'b0;
        shift_amt = '0;
        lane      = LANE_NONE;
        case (op)
            OP_RTYPE: begin
                cls     = CLS_R;
                // constant shifts take shamt as the second operand
                alu_src = (funct[5:2] == 4'b0000);
                case (funct)
                    F_SLL, F_SLLV: alu = ALU_SLL;
                    F_SRL, F_SRLV: alu = ALU_SRL;
                    F_SRA, F_SRAV: alu = ALU_SRA;
                    F_ADD, F_ADDU: alu = ALU_ADD;
                    F_SUB, F_SUBU: alu = ALU_SUB;
                    F_AND:         alu = ALU_AND;
                    F_OR:          alu = ALU_OR;
                    F_XOR:         alu = ALU_XOR;
                    F_NOR:         alu = ALU_NOR;
                    F_SLT:         alu = ALU_SLT;
                    default:       cls = CLS_ILL;
                endcase
            end
            OP_ADDI: begin cls = CLS_I; alu_src = 1'b1; alu = ALU_ADD; end
            OP_SLTI: begin cls = CLS_I; alu_src = 1'b1; alu = ALU_SLT; end
            OP_ANDI: begin cls = CLS_I; alu_src = 1'b1; alu = ALU_AND; end
            OP_ORI:  begin cls = CLS_I; alu_src = 1'b1; alu = ALU_OR;  end
            OP_XORI: begin cls = CLS_I; alu_src = 1'b1; alu = ALU_XOR; end
            OP_LUI: begin
                cls       = CLS_I;
                alu_src   = 1'b1;
                alu       = ALU_SLL;
                shift_amt = SHAMT_W'(16);
            end
            OP_LB, OP_LBU:         begin cls = CLS_LOAD;  alu_src = 1'b1; lane = LANE_B; end
            OP_LH, OP_LHU:         begin cls = CLS_LOAD;  alu_src = 1'b1; lane = LANE_H; end
            OP_LW, OP_LWU:         begin cls = CLS_LOAD;  alu_src = 1'b1; lane = LANE_W; end
            OP_SB:                 begin cls = CLS_STORE; alu_src = 1'b1; lane = LANE_B; end
            OP_SH:                 begin cls = CLS_STORE; alu_src = 1'b1; lane = LANE_H; end
            OP_SW:                 begin cls = CLS_STORE; alu_src = 1'b1; lane = LANE_W; end
`ifdef CTRL_BRANCH_EN
            OP_BEQ, OP_BNE: begin cls = CLS_BRANCH; alu = ALU_SUB; end
`endif
            default: ;
        endcase
        alu_ctrl = ALU_CTRL_W'(alu);
    end

    always_comb begin
        case (lane)
            LANE_B:  byte_mask = BYTE_EN_W'(1);
            LANE_H:  byte_mask = BYTE_EN_W'(3);
            LANE_W:  byte_mask = '1;
            default: byte_mask = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle MIPS control FSM with memory timeout and illegal-op trap.
// Define CTRL_BRANCH_EN to add the BEQ/BNE BRANCH state and pc_write.
module multicycle_ctrl_fsm
    import mips_ctrl_pkg::*;
#(
    parameter int ALU_CTRL_W  = 4,
    parameter int BYTE_EN_W   = 4,
    parameter int SHAMT_W     = 5,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  instr_valid,
    input  logic [5:0]            op,
    input  logic [5:0]            funct,
    input  logic                  mem_ready,
    input  logic                  zero,
    input  logic                  err_clr,
    output logic                  instr_ready,
    output logic                  busy,
    output logic                  pc_write,
    output logic [ALU_CTRL_W-1:0] alu_ctrl,
    output logic                  alu_src,
    output logic                  reg_dst,
    output logic [SHAMT_W-1:0]    shift_amt,
    output logic                  reg_write,
    output logic                  mem_to_reg,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [BYTE_EN_W-1:0]  mem_read_byte,
    output logic [BYTE_EN_W-1:0]  mem_write_byte,
    output logic                  illegal_op
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    logic [2:0]            state;
    logic [2:0]            state_nx;
    logic [5:0]            op_q;
    logic [5:0]            funct_q;
    logic [CNT_W-1:0]      wait_cnt;
    op_class_e             cls;
    logic [ALU_CTRL_W-1:0] dec_alu;
    logic                  dec_src;
    logic [SHAMT_W-1:0]    dec_shift;
    logic [BYTE_EN_W-1:0]  dec_mask;
    logic                  is_load;
    logic                  is_store;
    logic                  timeout;

    mips_op_decode #(
        .ALU_CTRL_W(ALU_CTRL_W),
        .BYTE_EN_W (BYTE_EN_W),
        .SHAMT_W   (SHAMT_W)
    ) u_dec (
        .op       (op_q),
        .funct    (funct_q),
        .cls      (cls),
        .alu_ctrl (dec_alu),
        .alu_src  (dec_src),
        .shift_amt(dec_shift),
        .byte_mask(dec_mask)
    );

    assign is_load  = (cls == CLS_LOAD);
    assign is_store = (cls == CLS_STORE);
    // this wait cycle is the last one allowed without mem_ready
    assign timeout  = (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            op_q     <= '0;
            funct_q  <= '0;
            wait_cnt <= '0;
        end else begin
            state <= state_nx;
            if (state == S_IDLE && instr_valid) begin
                op_q    <= op;
                funct_q <= funct;
            end
            if (state == S_MEM_ADDR) begin
                wait_cnt <= '0;
            end else if (state == S_MEM_WAIT && !mem_ready) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (instr_valid) state_nx = S_DECODE;
            S_DECODE: begin
                case (cls)
                    CLS_R, CLS_I:        state_nx = S_EXEC;
                    CLS_LOAD, CLS_STORE: state_nx = S_MEM_ADDR;
`ifdef CTRL_BRANCH_EN
                    CLS_BRANCH:          state_nx = S_BRANCH;
`endif
                    default:             state_nx = S_TRAP;
                endcase
            end
            S_EXEC:     state_nx = S_WB;
            S_MEM_ADDR: state_nx = S_MEM_WAIT;
            S_MEM_WAIT: begin
                if (mem_ready)    state_nx = is_load ? S_WB : S_IDLE;
                else if (timeout) state_nx = S_TRAP;
            end
            S_WB:       state_nx = S_IDLE;
`ifdef CTRL_BRANCH_EN
            S_BRANCH:   state_nx = S_IDLE;
`endif
            S_TRAP:     if (err_clr) state_nx = S_IDLE;
            default:    state_nx = S_IDLE;
        endcase
    end

    // gated by rst_n so every output reads 0 while reset is held
    assign instr_ready = rst_n && (state == S_IDLE);
    assign busy        = (state != S_IDLE);
    assign illegal_op  = (state == S_TRAP);

    always_comb begin
        pc_write       = 1'b0;
        alu_ctrl       = '0;
        alu_src        = 1'b0;
        reg_dst        = 1'b0;
        shift_amt      = '0;
        reg_write      = 1'b0;
        mem_to_reg     = 1'b0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_read_byte  = '0;
        mem_write_byte = '0;
        case (state)
            S_EXEC: begin
                alu_ctrl  = dec_alu;
                alu_src   = dec_src;
                shift_amt = dec_shift;
            end
            S_MEM_ADDR: begin
                alu_ctrl       = ALU_CTRL_W'(ALU_ADD);
                alu_src        = 1'b1;
                mem_read_byte  = is_load  ? dec_mask : '0;
                mem_write_byte = is_store ? dec_mask : '0;
            end
            S_MEM_WAIT: begin
                mem_read       = is_load;
                mem_write      = is_store;
                mem_read_byte  = is_load  ? dec_mask : '0;
                mem_write_byte = is_store ? dec_mask : '0;
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = is_load;
                reg_dst    = (cls == CLS_R);
            end
`ifdef CTRL_BRANCH_EN
            S_BRANCH: begin
                alu_ctrl = ALU_CTRL_W'(ALU_SUB);
                pc_write = (op_q == OP_BEQ) ? zero : !zero;
            end
`endif
            default: ;
        endcase
    end

`ifndef CTRL_BRANCH_EN
    logic unused_zero;
    assign unused_zero = zero;
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Scoreboard bench for multicycle_ctrl_fsm: a table-driven instruction
// model queues per-cycle expected outputs; a monitor compares each cycle.
module tb_multicycle_ctrl_fsm;

    localparam int TMO = 15;

    typedef struct packed {
        logic       instr_ready;
        logic       busy;
        logic       pc_write;
        logic [3:0] alu_ctrl;
        logic       alu_src;
        logic       reg_dst;
        logic [4:0] shift_amt;
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_read;
        logic       mem_write;
        logic [3:0] rbyte;
        logic [3:0] wbyte;
        logic       illegal;
    } obs_t;

    // kinds: 0 illegal, 1 R, 2 I, 3 load, 4 store, 5 branch
    int rfun[int];
    int imm[int];
    int lsz[int];
    int brn[int];

    logic clk = 1'b0;
    logic rst_n, instr_valid, mem_ready, zero, err_clr;
    logic [5:0] op, funct;
    logic instr_ready, busy, pc_write, alu_src, reg_dst;
    logic reg_write, mem_to_reg, mem_read, mem_write, illegal_op;
    logic [3:0] alu_ctrl, mem_read_byte, mem_write_byte;
    logic [4:0] shift_amt;

    obs_t  exp_q[$];
    string tag_q[$];
    int    checks = 0;
    int    failures = 0;

    always #5 clk = ~clk;

    multicycle_ctrl_fsm #(
        .ALU_CTRL_W(4), .BYTE_EN_W(4), .SHAMT_W(5), .MEM_TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid),
        .op(op), .funct(funct), .mem_ready(mem_ready), .zero(zero),
        .err_clr(err_clr), .instr_ready(instr_ready), .busy(busy),
        .pc_write(pc_write), .alu_ctrl(alu_ctrl), .alu_src(alu_src),
        .reg_dst(reg_dst), .shift_amt(shift_amt), .reg_write(reg_write),
        .mem_to_reg(mem_to_reg), .mem_read(mem_read),
        .mem_write(mem_write), .mem_read_byte(mem_read_byte),
        .mem_write_byte(mem_write_byte), .illegal_op(illegal_op)
    );

    obs_t  act_m, exp_m;
    string tag_m;

    always @(negedge clk) begin
        act_m = '0;
        act_m.instr_ready = instr_ready;
        act_m.busy        = busy;
        act_m.pc_write    = pc_write;
        act_m.alu_ctrl    = alu_ctrl;
        act_m.alu_src     = alu_src;
        act_m.reg_dst     = reg_dst;
        act_m.shift_amt   = shift_amt;
        act_m.reg_write   = reg_write;
        act_m.mem_to_reg  = mem_to_reg;
        act_m.mem_read    = mem_read;
        act_m.mem_write   = mem_write;
        act_m.rbyte       = mem_read_byte;
        act_m.wbyte       = mem_write_byte;
        act_m.illegal     = illegal_op;
        if (exp_q.size() > 0) begin
            exp_m = exp_q.pop_front();
            tag_m = tag_q.pop_front();
            checks++;
            if (act_m !== exp_m) begin
                failures++;
                $display("FAIL %s got=%h exp=%h t=%0t", tag_m, act_m, exp_m, $time);
            end
        end else if (busy !== 1'b0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_busy got=%b exp=0 t=%0t", busy, $time);
        end
    end

    function automatic obs_t idle_rec();
        obs_t r = '0;
        r.instr_ready = 1'b1;
        return r;
    endfunction

    function automatic obs_t busy_rec();
        obs_t r = '0;
        r.busy = 1'b1;
        return r;
    endfunction

    function automatic int classify(input logic [5:0] o, input logic [5:0] f,
                                    output int alu, output int sh, output int nb);
        alu = 0; sh = 0; nb = 0;
        if (o == 6'd0) begin
            if (!rfun.exists(int'(f))) return 0;
            alu = rfun[int'(f)];
            return 1;
        end
        if (imm.exists(int'(o))) begin
            alu = imm[int'(o)];
            sh  = (o == 6'b001111) ? 16 : 0;
            return 2;
        end
        if (lsz.exists(int'(o))) begin
            nb = lsz[int'(o)];
            return o[3] ? 4 : 3;
        end
        if (brn.exists(int'(o))) return 5;
        return 0;
    endfunction

    // per-cycle drive codes: 0/1 literal, 2 random
    int dm_q[$];
    int de_q[$];
    int dz_q[$];

    task automatic put(input obs_t r, input string t, input int m, input int e, input int z);
        exp_q.push_back(r);
        tag_q.push_back(t);
        dm_q.push_back(m);
        de_q.push_back(e);
        dz_q.push_back(z);
    endtask

    function automatic logic pick(input int c);
        return (c == 2) ? 1'($urandom) : 1'(c);
    endfunction

    task automatic drive_all(input logic [5:0] o, input logic [5:0] f);
        int n = dm_q.size();
        for (int i = 0; i < n; i++) begin
            instr_valid = (i == 0) ? 1'b1 : 1'($urandom);
            op          = (i == 0) ? o : 6'($urandom);
            funct       = (i == 0) ? f : 6'($urandom);
            mem_ready   = pick(dm_q[i]);
            err_clr     = pick(de_q[i]);
            zero        = pick(dz_q[i]);
            @(posedge clk);
            #1;
        end
        instr_valid = 1'b0;
        dm_q.delete(); de_q.delete(); dz_q.delete();
    endtask

    task automatic trap_cycles(input int k, input string nm);
        obs_t r = busy_rec();
        r.illegal = 1'b1;
        for (int j = 1; j <= k; j++)
            put(r, {nm, ".trap"}, 2, (j == k) ? 1 : 0, 2);
    endtask

    // w: MEM_WAIT cycle carrying mem_ready (w > TMO means never)
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int w,
                             input logic z, input int k, input string nm);
        obs_t r;
        int kind, alu, sh, nb, nw;
        logic [3:0] mask;
        kind = classify(o, f, alu, sh, nb);
        mask = 4'((1 << nb) - 1);
        put(idle_rec(), {nm, ".accept"}, 2, 2, 2);
        put(busy_rec(), {nm, ".decode"}, 2, 0, 2);
        case (kind)
            1, 2: begin
                r = busy_rec();
                r.alu_ctrl  = 4'(alu);
                r.alu_src   = (kind == 2) || (f < 6'd4);
                r.shift_amt = 5'(sh);
                put(r, {nm, ".exec"}, 2, 0, 2);
                r = busy_rec();
                r.reg_write = 1'b1;
                r.reg_dst   = (kind == 1);
                put(r, {nm, ".wb"}, 2, 0, 2);
            end
            3, 4: begin
                r = busy_rec();
                r.alu_src = 1'b1;
                if (kind == 3) r.rbyte = mask; else r.wbyte = mask;
                put(r, {nm, ".addr"}, 2, 0, 2);
                r.alu_src   = 1'b0;
                r.mem_read  = (kind == 3);
                r.mem_write = (kind == 4);
                nw = (w > TMO) ? TMO : w;
                for (int j = 1; j <= nw; j++)
                    put(r, {nm, ".wait"}, (j == w) ? 1 : 0, 0, 2);
                if (w > TMO) begin
                    trap_cycles(k, nm);
                end else if (kind == 3) begin
                    r = busy_rec();
                    r.reg_write  = 1'b1;
                    r.mem_to_reg = 1'b1;
                    put(r, {nm, ".wb"}, 2, 0, 2);
                end
            end
            5: begin
                r = busy_rec();
                r.alu_ctrl = 4'd1;
                r.pc_write = (o == 6'b000100) ? z : !z;
                put(r, {nm, ".branch"}, 2, 0, int'(z));
            end
            default: trap_cycles(k, nm);
        endcase
        drive_all(o, f);
    endtask

    task automatic reset_mid_wait();
        obs_t r;
        put(idle_rec(), "RST.accept", 0, 0, 0);
        put(busy_rec(), "RST.decode", 0, 0, 0);
        r = busy_rec();
        r.alu_src = 1'b1;
        r.rbyte   = 4'hf;
        put(r, "RST.addr", 0, 0, 0);
        r.alu_src  = 1'b0;
        r.mem_read = 1'b1;
        put(r, "RST.wait1", 0, 0, 0);
        put(r, "RST.wait2", 0, 0, 0);
        drive_all(6'b100011, 6'd0);
        rst_n = 1'b0;
        exp_q.push_back('0);
        tag_q.push_back("RST.assert");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.push_back(idle_rec());
        tag_q.push_back("RST.release");
        @(posedge clk);
        #1;
    endtask

    int rkeys[$];
    int ikeys[$];
    int mkeys[$];

    initial begin
        int sel, w;
        logic [5:0] o, f;
        rfun = '{0:6, 2:7, 3:8, 4:6, 6:7, 7:8, 32:0, 33:0, 34:1, 35:1,
                 36:2, 37:3, 38:4, 39:5, 42:9};
        imm  = '{8:0, 10:9, 12:2, 13:3, 14:4, 15:6};
        lsz  = '{32:1, 33:2, 35:4, 36:1, 37:2, 39:4, 40:1, 41:2, 43:4};
`ifdef CTRL_BRANCH_EN
        brn  = '{4:1, 5:1};
`endif
        foreach (rfun[key]) rkeys.push_back(key);
        foreach (imm[key])  ikeys.push_back(key);
        foreach (lsz[key])  mkeys.push_back(key);

        rst_n = 1'b0; instr_valid = 1'b0; op = '0; funct = '0;
        mem_ready = 1'b0; zero = 1'b0; err_clr = 1'b0;
        @(posedge clk);
        #1;
        exp_q.push_back('0);
        tag_q.push_back("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        run_instr(6'b000000, 6'b100000, 0, 1'b0, 1, "ADD");
        run_instr(6'b100000, 6'd0, 3, 1'b0, 1, "LB");
        run_instr(6'b101011, 6'd0, 99, 1'b0, 2, "SW_TMO");
        run_instr(6'b111111, 6'd0, 0, 1'b0, 3, "OP3F");
        run_instr(6'b000100, 6'd0, 0, 1'b1, 1, "BEQ_Z1");
        run_instr(6'b000101, 6'd0, 0, 1'b1, 1, "BNE_Z1");
        run_instr(6'b100001, 6'd0, TMO, 1'b0, 1, "LH_EDGE");
        run_instr(6'b001111, 6'd0, 0, 1'b0, 1, "LUI");
        run_instr(6'b000000, 6'b000011, 0, 1'b0, 1, "SRA");
        run_instr(6'b000000, 6'b001000, 0, 1'b0, 2, "RBAD");
        reset_mid_wait();

        for (int n = 0; n < 300; n++) begin
            sel = $urandom_range(0, 9);
            o = 6'($urandom);
            f = 6'($urandom);
            w = $urandom_range(0, 9);
            w = (w == 0) ? TMO + 1 : (w == 1) ? TMO : $urandom_range(1, 5);
            case (sel)
                0, 1: begin o = 6'd0; f = 6'(rkeys[$urandom_range(0, rkeys.size() - 1)]); end
                2:    o = 6'd0;
                3:    o = 6'(ikeys[$urandom_range(0, ikeys.size() - 1)]);
                4, 5: o = 6'(mkeys[$urandom_range(0, mkeys.size() - 1)]);
                6:    o = 6'($urandom_range(4, 5));
                default: ;
            endcase
            if ($urandom_range(0, 3) == 0) begin
                exp_q.push_back(idle_rec());
                tag_q.push_back("gap");
                @(posedge clk);
                #1;
            end
            run_instr(o, f, w, 1'($urandom), $urandom_range(1, 3), "RND");
        end

        repeat (3) @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain left=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
